// File: rtl/rblwe_enc_param.sv
// Ring-binary-LWE encryption core: c1 = a*e1 + e2, c2 = p*e1 + e3 + encode(m) in Z_q[x]/(x^N+1).
// A bit-serial negacyclic multiply-accumulate over one shared N-coefficient accumulator serves both products.
module rblwe_enc_param #(
  parameter int N     = 512,
  parameter int LOG_Q = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*LOG_Q-1:0]   a,
  input  logic [N*LOG_Q-1:0]   p,
  input  logic [N-1:0]         e1,
  input  logic [N-1:0]         e2,
  input  logic [N-1:0]         e3,
  input  logic [N-1:0]         m,
  input  logic                 out_ready,
  output logic [N*LOG_Q-1:0]   c1,
  output logic [N*LOG_Q-1:0]   c2,
  output logic                 valid,
  output logic                 busy
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    C1_MUL,
    C1_ADD,
    C2_MUL,
    C2_ADD,
    DONE
  } state_t;

  state_t               state, next_state;
  logic [N*LOG_Q-1:0]   acc;
  logic [N*LOG_Q-1:0]   acc_step;
  logic [N*LOG_Q-1:0]   sum1;
  logic [N*LOG_Q-1:0]   sum2;
  logic [N*LOG_Q-1:0]   x_sel;
  logic [N-1:0]         e1_sh;
  logic [N-1:0]         e1_lat;
  logic [CNT_W-1:0]     cnt;
  logic                 bit_b;

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    valid      = (state == DONE);
    case (state)
      IDLE:    if (start) next_state = C1_MUL;
      C1_MUL:  if (cnt == CNT_W'(N-1)) next_state = C1_ADD;
      C1_ADD:  next_state = C2_MUL;
      C2_MUL:  if (cnt == CNT_W'(N-1)) next_state = C2_ADD;
      C2_ADD:  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One Horner step: multiply acc by x (top coefficient wraps negated) and add X if the e1 bit is set.
  always_comb begin
    x_sel    = (state == C2_MUL) ? p : a;
    bit_b    = e1_sh[N-1];
    acc_step = '0;
    acc_step[0 +: LOG_Q] = LOG_Q'(0) - acc[(N-1)*LOG_Q +: LOG_Q]
                           + (bit_b ? x_sel[0 +: LOG_Q] : LOG_Q'(0));
    for (int i = 1; i < N; i++) begin
      acc_step[i*LOG_Q +: LOG_Q] = acc[(i-1)*LOG_Q +: LOG_Q]
                                   + (bit_b ? x_sel[i*LOG_Q +: LOG_Q] : LOG_Q'(0));
    end
  end

  // Error and message terms; m[i] contributes q/2 through the coefficient MSB.
  always_comb begin
    sum1 = '0;
    sum2 = '0;
    for (int i = 0; i < N; i++) begin
      sum1[i*LOG_Q +: LOG_Q] = acc[i*LOG_Q +: LOG_Q] + {{(LOG_Q-1){1'b0}}, e2[i]};
      sum2[i*LOG_Q +: LOG_Q] = acc[i*LOG_Q +: LOG_Q] + {{(LOG_Q-1){1'b0}}, e3[i]}
                               + {m[i], {(LOG_Q-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // e1 is kept in a latched copy so the second product can reuse it after the shift register drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      c1     <= '0;
      c2     <= '0;
      e1_sh  <= '0;
      e1_lat <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            e1_sh  <= e1;
            e1_lat <= e1;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        C1_MUL, C2_MUL: begin
          acc   <= acc_step;
          e1_sh <= e1_sh << 1;
          cnt   <= cnt + CNT_W'(1);
        end
        C1_ADD: begin
          c1    <= sum1;
          acc   <= '0;
          e1_sh <= e1_lat;
          cnt   <= '0;
        end
        C2_ADD: begin
          c2 <= sum2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rblwe_enc_param.sv
// Scoreboard bench for rblwe_enc_param: directed ring vectors, reset abort, handshake stalls and random jobs.
module tb_rblwe_enc_param;

  localparam int N   = 4;
  localparam int LQ  = 4;
  localparam int W   = N * LQ;
  localparam int LAT = 2 * N + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0, p = '0;
  logic [N-1:0]  e1 = '0, e2 = '0, e3 = '0, m = '0;
  logic [W-1:0]  c1, c2;
  logic          valid, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hold_req = 0;

  typedef struct {
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    int           acc_cyc;
  } exp_t;
  exp_t sb[$];

  rblwe_enc_param #(.N(N), .LOG_Q(LQ)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .p(p), .e1(e1), .e2(e2), .e3(e3), .m(m),
    .out_ready(out_ready), .c1(c1), .c2(c2), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Schoolbook negacyclic product: x^(i+j) with i+j >= N folds back as -x^(i+j-N).
  function automatic logic [W-1:0] negamul(input logic [W-1:0] x, input logic [N-1:0] s);
    int coef[N];
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) coef[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (s[j]) begin
          if (i + j < N) coef[i+j]   += int'(x[i*LQ +: LQ]);
          else           coef[i+j-N] -= int'(x[i*LQ +: LQ]);
        end
    r = '0;
    for (int k = 0; k < N; k++) r[k*LQ +: LQ] = coef[k][LQ-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] add_terms(input logic [W-1:0] base, input logic [N-1:0] e,
                                             input logic [N-1:0] mm);
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      v = int'(base[k*LQ +: LQ]) + (e[k] ? 1 : 0) + (mm[k] ? (1 << (LQ-1)) : 0);
      r[k*LQ +: LQ] = v[LQ-1:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue one job: wait for IDLE, pulse start, push the expected result, then optionally poke start while busy.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tp, input logic [N-1:0] te1,
                               input logic [N-1:0] te2, input logic [N-1:0] te3, input logic [N-1:0] tm,
                               input logic [W-1:0] x1, input logic [W-1:0] x2,
                               input int hold, input bit poke);
    exp_t e;
    bit   idle_seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    if (!idle_seen) checkOutput("idle_wait", W'(busy), W'(0));
    a = ta; p = tp; e1 = te1; e2 = te2; e3 = te3; m = tm;
    hold_req = hold;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.c1 = x1;
    e.c2 = x2;
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    e1 = N'($urandom);
    if (poke) begin
      for (int k = 0; k < 2 * N; k++) begin
        @(negedge clk);
        start = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic randomJob(input int hold, input bit poke);
    logic [W-1:0] ta, tp;
    logic [N-1:0] te1, te2, te3, tm;
    ta = W'({$urandom, $urandom});
    tp = W'({$urandom, $urandom});
    te1 = N'($urandom); te2 = N'($urandom); te3 = N'($urandom); tm = N'($urandom);
    applyStimulus(ta, tp, te1, te2, te3, tm,
                  add_terms(negamul(ta, te1), te2, '0),
                  add_terms(negamul(tp, te1), te3, tm), hold, poke);
  endtask

  // Monitor: drives out_ready, checks latency, hold stability and the popped expectation at each handshake.
  logic         valid_q = 1'b0;
  logic         ready_q = 1'b0;
  logic [W-1:0] c1_cap, c2_cap;
  int           hold_cnt = 0;
  exp_t         got;

  always @(negedge clk) begin
    if (rst) begin
      if (valid_q && ready_q)
        checkOutput("valid_clear", W'(valid), W'(0));
      else if (valid_q)
        checkOutput("valid_held", W'(valid), W'(1));
      if (valid && !valid_q) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", W'(valid), W'(0));
        end else begin
          checkOutput("latency", W'(cyc - sb[0].acc_cyc), W'(LAT));
        end
        c1_cap = c1;
        c2_cap = c2;
        hold_cnt = hold_req;
      end else if (valid && valid_q) begin
        checkOutput("hold_c1", c1, c1_cap);
        checkOutput("hold_c2", c2, c2_cap);
      end
      if (valid && hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = $urandom_range(0, 3) != 0;
      end
      if (valid && out_ready && sb.size() != 0) begin
        got = sb.pop_front();
        checkOutput("c1", c1, got.c1);
        checkOutput("c2", c2, got.c2);
      end
    end
    valid_q = valid && rst;
    ready_q = out_ready;
  end

  initial begin
    #1;
    checkOutput("rst_valid", W'(valid), W'(0));
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_c1", c1, '0);
    checkOutput("rst_c2", c2, '0);
    #21 rst = 1'b1;

    applyStimulus({4'd4, 4'd3, 4'd2, 4'd1}, '0, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                  {4'd3, 4'd2, 4'd1, 4'd12}, '0, 0, 1'b0);
    applyStimulus('0, {4'd5, 4'd0, 4'd0, 4'd0}, 4'b0010, 4'b0000, 4'b1000, 4'b0001,
                  '0, {4'd1, 4'd0, 4'd0, 4'd3}, 0, 1'b0);
    applyStimulus({4'd7, 4'd9, 4'd11, 4'd13}, {4'd15, 4'd2, 4'd6, 4'd8}, 4'b0000, 4'b1111, 4'b1111, 4'b1111,
                  {4'd1, 4'd1, 4'd1, 4'd1}, {4'd9, 4'd9, 4'd9, 4'd9}, 5, 1'b1);

    // Abort a job in the middle of the second product.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    a = '1; p = '1; e1 = 4'b1011; e2 = 4'b1111; e3 = '0; m = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (N + 2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_valid", W'(valid), W'(0));
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_c1", c1, '0);
    checkOutput("abort_c2", c2, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 40; n++) randomJob($urandom_range(0, 3), $urandom_range(0, 3) == 0);

    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) checkOutput("drain", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
